// File: rtl/sd_spi_arbiter.sv
// Two-requester round-robin arbiter sharing one SD card SPI byte engine, with chip-select gap between owners.
// Optional engine watchdog enabled by defining SD_ARB_WATCHDOG_EN.
module sd_spi_arbiter #(
    parameter int GAP_CYC = 2,
    parameter int TMO_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    input  logic [7:0] tx0,
    input  logic [7:0] tx1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [7:0] rx_data,
    output logic       err,
    output logic       sd_cs,
    output logic       eng_start,
    output logic [7:0] eng_tx,
    input  logic       eng_done,
    input  logic [7:0] eng_rx
);

    typedef enum logic [2:0] {IDLE, SEL, XFER, HOLD, GAP} state_t;

    state_t     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic [1:0] done_q, done_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] eng_tx_q, eng_tx_d;
    logic       sd_cs_q, sd_cs_d;
    logic       eng_start_q, eng_start_d;
    logic       last_q, last_d;
    logic [3:0] gap_cnt_q, gap_cnt_d;
    logic       owner;
    logic       win;

`ifdef SD_ARB_WATCHDOG_EN
    localparam int TMO_W = $clog2(TMO_CYC) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

    logic             err_q, err_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q     <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign err = err_q;
`else
    logic unused_tmo;
    assign unused_tmo = (TMO_CYC == 0);
    assign err        = 1'b0;
`endif

    assign owner = gnt_q[1];

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = 2'b00;
        rx_data_d   = rx_data_q;
        eng_tx_d    = eng_tx_q;
        sd_cs_d     = sd_cs_q;
        eng_start_d = 1'b0;
        last_d      = last_q;
        gap_cnt_d   = gap_cnt_q;
        win         = 1'b0;
`ifdef SD_ARB_WATCHDOG_EN
        err_d       = 1'b0;
        tmo_cnt_d   = (state_q == XFER) ? tmo_cnt_q + 1'b1 : '0;
`endif
        case (state_q)
            IDLE: begin
                gnt_d   = 2'b00;
                sd_cs_d = 1'b1;
                if (|req) begin
                    // last_q remembers the previous owner so a tie goes to the other side
                    win       = (req == 2'b11) ? ~last_q : req[1];
                    last_d    = win;
                    gnt_d     = win ? 2'b10 : 2'b01;
                    sd_cs_d   = 1'b0;
                    eng_tx_d  = win ? tx1 : tx0;
                    state_d   = SEL;
                end
            end
            SEL: begin
                eng_start_d = 1'b1;
                state_d     = XFER;
            end
            XFER: begin
                if (eng_done) begin
                    rx_data_d = eng_rx;
                    done_d    = gnt_q;
                    if (lock[owner]) begin
                        state_d = HOLD;
                    end else begin
                        gnt_d     = 2'b00;
                        sd_cs_d   = 1'b1;
                        gap_cnt_d = 4'(GAP_CYC - 1);
                        state_d   = GAP;
                    end
                end
`ifdef SD_ARB_WATCHDOG_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    err_d     = 1'b1;
                    gnt_d     = 2'b00;
                    sd_cs_d   = 1'b1;
                    gap_cnt_d = 4'(GAP_CYC - 1);
                    state_d   = GAP;
                end
`endif
            end
            HOLD: begin
                if (req[owner]) begin
                    eng_tx_d    = owner ? tx1 : tx0;
                    eng_start_d = 1'b1;
                    state_d     = XFER;
                end else if (!lock[owner]) begin
                    gnt_d     = 2'b00;
                    sd_cs_d   = 1'b1;
                    gap_cnt_d = 4'(GAP_CYC - 1);
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                gnt_d   = 2'b00;
                sd_cs_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            gnt_q       <= 2'b00;
            done_q      <= 2'b00;
            rx_data_q   <= 8'h00;
            eng_tx_q    <= 8'h00;
            sd_cs_q     <= 1'b1;
            eng_start_q <= 1'b0;
            last_q      <= 1'b1;
            gap_cnt_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rx_data_q   <= rx_data_d;
            eng_tx_q    <= eng_tx_d;
            sd_cs_q     <= sd_cs_d;
            eng_start_q <= eng_start_d;
            last_q      <= last_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rx_data   = rx_data_q;
    assign eng_tx    = eng_tx_q;
    assign sd_cs     = sd_cs_q;
    assign eng_start = eng_start_q;

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Directed testbench for sd_spi_arbiter: single byte, round-robin, locked burst,
// reset mid-transfer and engine stall (watchdog or indefinite wait depending on SD_ARB_WATCHDOG_EN).
module tb_sd_spi_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic [1:0] lock;
    logic [7:0] tx0;
    logic [7:0] tx1;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [7:0] rx_data;
    logic       err;
    logic       sd_cs;
    logic       eng_start;
    logic [7:0] eng_tx;
    logic       eng_done;
    logic [7:0] eng_rx;

    int checks = 0;
    int errors = 0;

    sd_spi_arbiter #(.GAP_CYC(2), .TMO_CYC(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .tx0       (tx0),
        .tx1       (tx1),
        .gnt       (gnt),
        .done      (done),
        .rx_data   (rx_data),
        .err       (err),
        .sd_cs     (sd_cs),
        .eng_start (eng_start),
        .eng_tx    (eng_tx),
        .eng_done  (eng_done),
        .eng_rx    (eng_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: outputs are sampled 1ns after the rising edge, inputs changed at the same point.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Starts in the SEL cycle of an unlocked byte and ends in the IDLE cycle after the gap.
    task automatic xferNoLock(input logic [1:0] exp_gnt, input logic [7:0] exp_tx, input logic [7:0] rx_byte);
        checkOutput("sel_gnt", gnt, exp_gnt);
        checkOutput("sel_cs", sd_cs, 1'b0);
        checkOutput("sel_tx", eng_tx, exp_tx);
        checkOutput("sel_start", eng_start, 1'b0);
        applyStimulus();
        checkOutput("xfer_start", eng_start, 1'b1);
        checkOutput("xfer_tx", eng_tx, exp_tx);
        checkOutput("xfer_gnt", gnt, exp_gnt);
        eng_done = 1'b1;
        eng_rx   = rx_byte;
        applyStimulus();
        eng_done = 1'b0;
        checkOutput("done_pulse", done, exp_gnt);
        checkOutput("done_rx", rx_data, rx_byte);
        checkOutput("gap1_gnt", gnt, 2'b00);
        checkOutput("gap1_cs", sd_cs, 1'b1);
        checkOutput("gap1_start", eng_start, 1'b0);
        applyStimulus();
        checkOutput("gap2_done", done, 2'b00);
        checkOutput("gap2_cs", sd_cs, 1'b1);
        checkOutput("gap2_gnt", gnt, 2'b00);
        applyStimulus();
        checkOutput("idle_gnt", gnt, 2'b00);
        checkOutput("idle_cs", sd_cs, 1'b1);
    endtask

    initial begin
        rst      = 1'b0;
        req      = 2'b00;
        lock     = 2'b00;
        tx0      = 8'h00;
        tx1      = 8'h00;
        eng_done = 1'b0;
        eng_rx   = 8'h00;

        applyStimulus();
        applyStimulus();
        checkOutput("rst_gnt", gnt, 2'b00);
        checkOutput("rst_cs", sd_cs, 1'b1);
        checkOutput("rst_done", done, 2'b00);
        checkOutput("rst_err", err, 1'b0);
        checkOutput("rst_start", eng_start, 1'b0);
        checkOutput("rst_tx", eng_tx, 8'h00);
        checkOutput("rst_rx", rx_data, 8'h00);
        rst = 1'b1;
        applyStimulus();

        // Single unlocked byte from requester 0
        req = 2'b01;
        tx0 = 8'h40;
        applyStimulus();
        req = 2'b00;
        xferNoLock(2'b01, 8'h40, 8'hA5);
        applyStimulus();
        checkOutput("t1_stay_idle", gnt, 2'b00);

        // Both requesting from reset: 01, 10, 01
        rst = 1'b0;
        applyStimulus();
        req = 2'b11;
        tx0 = 8'h11;
        tx1 = 8'h22;
        rst = 1'b1;
        applyStimulus();
        xferNoLock(2'b01, 8'h11, 8'h61);
        applyStimulus();
        xferNoLock(2'b10, 8'h22, 8'h62);
        applyStimulus();
        xferNoLock(2'b01, 8'h11, 8'h63);
        req = 2'b00;
        applyStimulus();

        // Requester 1 locked burst of three bytes while requester 0 waits
        req  = 2'b11;
        lock = 2'b10;
        tx1  = 8'h51;
        applyStimulus();
        checkOutput("lk_sel_gnt", gnt, 2'b10);
        checkOutput("lk_sel_tx", eng_tx, 8'h51);
        applyStimulus();
        checkOutput("lk_b1_start", eng_start, 1'b1);
        eng_done = 1'b1;
        eng_rx   = 8'h01;
        applyStimulus();
        eng_done = 1'b0;
        tx1      = 8'h00;
        checkOutput("lk_b1_done", done, 2'b10);
        checkOutput("lk_hold_cs", sd_cs, 1'b0);
        checkOutput("lk_hold_gnt", gnt, 2'b10);
        checkOutput("lk_hold_start", eng_start, 1'b0);
        applyStimulus();
        checkOutput("lk_b2_start", eng_start, 1'b1);
        checkOutput("lk_b2_tx", eng_tx, 8'h00);
        checkOutput("lk_b2_cs", sd_cs, 1'b0);
        eng_done = 1'b1;
        eng_rx   = 8'h02;
        applyStimulus();
        eng_done = 1'b0;
        tx1      = 8'hFF;
        checkOutput("lk_b2_done", done, 2'b10);
        checkOutput("lk_b2_rx", rx_data, 8'h02);
        applyStimulus();
        checkOutput("lk_b3_start", eng_start, 1'b1);
        checkOutput("lk_b3_tx", eng_tx, 8'hFF);
        checkOutput("lk_b3_cs", sd_cs, 1'b0);
        eng_done = 1'b1;
        eng_rx   = 8'h03;
        applyStimulus();
        eng_done = 1'b0;
        req      = 2'b01;
        checkOutput("lk_b3_done", done, 2'b10);
        applyStimulus();
        checkOutput("lk_hold_ign_gnt", gnt, 2'b10);
        checkOutput("lk_hold_ign_cs", sd_cs, 1'b0);
        checkOutput("lk_hold_ign_start", eng_start, 1'b0);
        lock = 2'b00;
        tx0  = 8'h3C;
        applyStimulus();
        checkOutput("lk_gap1_gnt", gnt, 2'b00);
        checkOutput("lk_gap1_cs", sd_cs, 1'b1);
        applyStimulus();
        checkOutput("lk_gap2_cs", sd_cs, 1'b1);
        applyStimulus();
        checkOutput("lk_idle_gnt", gnt, 2'b00);
        applyStimulus();
        req = 2'b00;
        xferNoLock(2'b01, 8'h3C, 8'hC3);

        // Stray engine completion outside XFER
        eng_done = 1'b1;
        eng_rx   = 8'hEE;
        applyStimulus();
        eng_done = 1'b0;
        checkOutput("stray_done", done, 2'b00);
        checkOutput("stray_rx", rx_data, 8'hC3);

        // Reset three cycles after eng_start, late eng_done afterwards
        req = 2'b01;
        tx0 = 8'h77;
        applyStimulus();
        req = 2'b00;
        applyStimulus();
        checkOutput("mr_start", eng_start, 1'b1);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        #1;
        checkOutput("mr_async_cs", sd_cs, 1'b1);
        checkOutput("mr_async_gnt", gnt, 2'b00);
        checkOutput("mr_async_tx", eng_tx, 8'h00);
        checkOutput("mr_async_rx", rx_data, 8'h00);
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        eng_done = 1'b1;
        eng_rx   = 8'h99;
        applyStimulus();
        eng_done = 1'b0;
        checkOutput("mr_late_done", done, 2'b00);
        checkOutput("mr_late_rx", rx_data, 8'h00);
        req = 2'b10;
        tx1 = 8'h5A;
        applyStimulus();
        req = 2'b00;
        xferNoLock(2'b10, 8'h5A, 8'hC3);

        // Engine never completes
        req = 2'b01;
        tx0 = 8'h12;
        applyStimulus();
        req = 2'b00;
        applyStimulus();
        checkOutput("st_start", eng_start, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            applyStimulus();
`ifdef SD_ARB_WATCHDOG_EN
            checkOutput("st_err", err, (k == 16) ? 1'b1 : 1'b0);
            checkOutput("st_gnt", gnt, (k < 16) ? 2'b01 : 2'b00);
            checkOutput("st_cs", sd_cs, (k < 16) ? 1'b0 : 1'b1);
            checkOutput("st_done", done, 2'b00);
`else
            checkOutput("st_err", err, 1'b0);
            checkOutput("st_gnt", gnt, 2'b01);
            checkOutput("st_cs", sd_cs, 1'b0);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
